fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that shares one show-ahead SRAM FIFO write port between `N_REQ` valid/ready producers. It sits directly in front of the FIFO's `wr_en_i`/`data_i`/`full_o` pins. A producer that wins keeps the grant for a burst of up to `MAX_BURST` beats, so one producer's data stays contiguous in the FIFO. Fairness between producers comes from a rotating priority pointer.

---
 rtl/fifo_wr_arbiter.sv | 154 +++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
// fifo_wr_arbiter : round-robin burst arbiter sharing one FIFO write port
// Revision 1.0
// ============================================================================
`default_nettype none

module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [N_REQ-1:0]                      req_valid_i,
    input  logic [N_REQ*WIDTH-1:0]                req_data_i,
    output logic [N_REQ-1:0]                      req_ready_o,
    input  logic                                  fifo_full_i,
    output logic                                  fifo_wr_en_o,
    output logic [WIDTH-1:0]                      fifo_data_o,
    output logic [N_REQ-1:0]                      grant_o,
    output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] grant_id_o,
    output logic                                  busy_o
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    logic [0:0]       state_q,    state_d;
    logic [PTR_W-1:0] rr_ptr_q,   rr_ptr_d;
    logic [PTR_W-1:0] lock_id_q,  lock_id_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic             win_found;
    logic [PTR_W-1:0] win_idx;
    logic [PTR_W:0]   cand_sum;
    logic [PTR_W-1:0] cand_idx;
    logic             grant_vld;
    logic [PTR_W-1:0] grant_idx;
    logic             beat;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(N_REQ - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Search from rr_ptr upwards, wrapping modulo N_REQ (works for non-power-of-2 N_REQ)
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_sum  = '0;
        cand_idx  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
            if (cand_sum >= (PTR_W+1)'(N_REQ)) begin
                cand_sum = cand_sum - (PTR_W+1)'(N_REQ);
            end
            cand_idx = cand_sum[PTR_W-1:0];
            if (!win_found && req_valid_i[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        if (state_q == S_BURST) begin
            grant_vld = 1'b1;
            grant_idx = lock_id_q;
        end else if (win_found) begin
            grant_vld = 1'b1;
            grant_idx = win_idx;
        end
        beat = grant_vld && req_valid_i[grant_idx] && !fifo_full_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            lock_id_q  <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_id_q  <= lock_id_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_id_d  = lock_id_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (beat) begin
                    if (MAX_BURST == 1) begin
                        rr_ptr_d = ptr_inc(win_idx);
                    end else begin
                        state_d    = S_BURST;
                        lock_id_d  = win_idx;
                        beat_cnt_d = CNT_W'(1);
                    end
                end
            end
            S_BURST: begin
                if (!req_valid_i[lock_id_q]) begin
                    state_d    = S_IDLE;
                    rr_ptr_d   = ptr_inc(lock_id_q);
                    beat_cnt_d = '0;
                end else if (beat) begin
                    if (beat_cnt_q == CNT_W'(MAX_BURST - 1)) begin
                        state_d    = S_IDLE;
                        rr_ptr_d   = ptr_inc(lock_id_q);
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are gated by rst_ni so they drop immediately, not at the next edge
    always_comb begin
        fifo_wr_en_o = 1'b0;
        req_ready_o  = '0;
        grant_o      = '0;
        grant_id_o   = '0;
        busy_o       = 1'b0;
        fifo_data_o  = '0;
        if (rst_ni) begin
            busy_o = (state_q == S_BURST);
            if (grant_vld) begin
                grant_o     = N_REQ'(1) << grant_idx;
                grant_id_o  = grant_idx;
                fifo_data_o = req_data_i[grant_idx*WIDTH +: WIDTH];
            end
            if (beat) begin
                fifo_wr_en_o = 1'b1;
                req_ready_o  = N_REQ'(1) << grant_idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// ============================================================================
// tb_fifo_wr_arbiter : scoreboard bench for fifo_wr_arbiter (N_REQ=4, MAX_BURST=4)
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_fifo_wr_arbiter;

    localparam int N_REQ     = 4;
    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;

    logic                   clk_i;
    logic                   rst_ni;
    logic [N_REQ-1:0]       req_valid_i;
    logic [N_REQ*WIDTH-1:0] req_data_i;
    logic [N_REQ-1:0]       req_ready_o;
    logic                   fifo_full_i;
    logic                   fifo_wr_en_o;
    logic [WIDTH-1:0]       fifo_data_o;
    logic [N_REQ-1:0]       grant_o;
    logic [1:0]             grant_id_o;
    logic                   busy_o;

    fifo_wr_arbiter #(
        .N_REQ     (N_REQ),
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST)
    ) u_dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_data_i   (req_data_i),
        .req_ready_o  (req_ready_o),
        .fifo_full_i  (fifo_full_i),
        .fifo_wr_en_o (fifo_wr_en_o),
        .fifo_data_o  (fifo_data_o),
        .grant_o      (grant_o),
        .grant_id_o   (grant_id_o),
        .busy_o       (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // producer k holds pdata[k][phead[k]] until it sees ready
    logic [7:0] pdata [N_REQ][16];
    int         phead [N_REQ];
    int         pcnt  [N_REQ];
    logic [3:0] pen;

    logic [9:0] exp_q [$];

    logic       s_wr, s_busy;
    logic [1:0] s_gid;
    logic [3:0] s_grant, s_ready;
    logic [7:0] s_data;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_valids();
        for (int k = 0; k < N_REQ; k++) begin
            req_valid_i[k]          = 1'b0;
            req_data_i[k*WIDTH +: WIDTH] = 8'h00;
            if (pen[k] && (phead[k] < pcnt[k])) begin
                req_valid_i[k]               = 1'b1;
                req_data_i[k*WIDTH +: WIDTH] = pdata[k][phead[k]];
            end
        end
    endtask

    task automatic load(input int k, input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) pdata[k][i] = base + 8'(i);
        phead[k] = 0;
        pcnt[k]  = n;
    endtask

    task automatic push_exp(input int k, input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({2'(k), base + 8'(i)});
    endtask

    task automatic sample();
        logic [9:0] e;
        logic [3:0] oh;
        if (fifo_wr_en_o) begin
            check_eq("sb_has_entry", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                oh = 4'b0001 << e[9:8];
                check_eq("sb_grant_id", grant_id_o, e[9:8]);
                check_eq("sb_data", fifo_data_o, e[7:0]);
                check_eq("sb_ready", req_ready_o, oh);
            end
        end else begin
            check_eq("ready_no_beat", req_ready_o, 0);
        end
        s_wr    = fifo_wr_en_o;
        s_busy  = busy_o;
        s_gid   = grant_id_o;
        s_grant = grant_o;
        s_ready = req_ready_o;
        s_data  = fifo_data_o;
    endtask

    task automatic step(input logic full);
        fifo_full_i = full;
        @(negedge clk_i);
        sample();
        @(posedge clk_i);
        #1;
        for (int k = 0; k < N_REQ; k++) if (s_ready[k]) phead[k]++;
        drive_valids();
    endtask

    task automatic do_reset();
        rst_ni      = 1'b0;
        fifo_full_i = 1'b0;
        pen         = 4'hF;
        for (int k = 0; k < N_REQ; k++) begin
            phead[k] = 0;
            pcnt[k]  = 0;
        end
        drive_valids();
        exp_q.delete();
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] busy_exp;
        rst_ni      = 1'b0;
        fifo_full_i = 1'b0;
        req_valid_i = '0;
        req_data_i  = '0;

        // reset state
        do_reset();
        step(1'b0);
        check_eq("rst_wr_en", s_wr, 0);
        check_eq("rst_grant", s_grant, 0);
        check_eq("rst_busy", s_busy, 0);
        check_eq("rst_data", s_data, 0);

        // streaming across a burst boundary
        do_reset();
        load(1, 8'h10, 6);
        push_exp(1, 8'h10, 6);
        drive_valids();
        busy_exp = 6'b101110;
        for (int i = 0; i < 6; i++) begin
            step(1'b0);
            check_eq("stream_wr", s_wr, 1);
            check_eq("stream_gid", s_gid, 1);
            check_eq("stream_busy", s_busy, busy_exp[i]);
        end
        step(1'b0);
        check_eq("stream_end_wr", s_wr, 0);
        check_eq("stream_drain", exp_q.size(), 0);

        // round-robin rotation followed by wrap-around 3 -> 0
        do_reset();
        load(0, 8'h00, 8);
        load(1, 8'h10, 4);
        load(2, 8'h20, 4);
        load(3, 8'h30, 4);
        push_exp(0, 8'h00, 4);
        push_exp(1, 8'h10, 4);
        push_exp(2, 8'h20, 4);
        push_exp(3, 8'h30, 4);
        push_exp(0, 8'h04, 4);
        drive_valids();
        for (int i = 1; i <= 20; i++) begin
            step(1'b0);
            check_eq("rr_wr", s_wr, 1);
            if (i == 13) check_eq("rr_ptr3_grant", s_gid, 3);
            if (i == 17) check_eq("wrap_grant0", s_gid, 0);
        end
        step(1'b0);
        check_eq("rr_end_wr", s_wr, 0);
        check_eq("rr_drain", exp_q.size(), 0);

        // backpressure mid-burst
        do_reset();
        load(0, 8'h40, 4);
        push_exp(0, 8'h40, 4);
        drive_valids();
        step(1'b0);
        step(1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1);
            check_eq("full_wr", s_wr, 0);
            check_eq("full_ready", s_ready, 0);
            check_eq("full_grant", s_grant, 4'b0001);
            check_eq("full_busy", s_busy, 1);
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0);
            check_eq("after_full_wr", s_wr, 1);
        end
        step(1'b0);
        check_eq("after_burst_busy", s_busy, 0);
        check_eq("no_grant_data", s_data, 0);
        check_eq("no_grant_gid", s_gid, 0);
        check_eq("bp_drain", exp_q.size(), 0);

        // valid drop inside a burst costs one bubble
        do_reset();
        load(0, 8'hA0, 2);
        load(2, 8'hC0, 2);
        push_exp(0, 8'hA0, 2);
        push_exp(2, 8'hC0, 2);
        drive_valids();
        step(1'b0);
        step(1'b0);
        step(1'b0);
        check_eq("drop_bubble_wr", s_wr, 0);
        check_eq("drop_bubble_busy", s_busy, 1);
        step(1'b0);
        check_eq("drop_next_wr", s_wr, 1);
        check_eq("drop_next_gid", s_gid, 2);
        step(1'b0);
        step(1'b0);
        step(1'b0);
        check_eq("drop_drain", exp_q.size(), 0);

        // asynchronous reset in the middle of a producer 2 burst
        do_reset();
        load(2, 8'hE0, 6);
        push_exp(2, 8'hE0, 2);
        drive_valids();
        step(1'b0);
        step(1'b0);
        #2 rst_ni = 1'b0;
        #1;
        check_eq("arst_wr", fifo_wr_en_o, 0);
        check_eq("arst_ready", req_ready_o, 0);
        check_eq("arst_grant", grant_o, 0);
        check_eq("arst_gid", grant_id_o, 0);
        check_eq("arst_busy", busy_o, 0);
        check_eq("arst_data", fifo_data_o, 0);
        @(posedge clk_i);
        #1;
        check_eq("arst_hold_wr", fifo_wr_en_o, 0);
        pen[2] = 1'b0;
        load(0, 8'h01, 1);
        load(3, 8'h31, 1);
        push_exp(0, 8'h01, 1);
        push_exp(3, 8'h31, 1);
        drive_valids();
        rst_ni = 1'b1;
        step(1'b0);
        check_eq("post_rst_wr", s_wr, 1);
        check_eq("post_rst_gid", s_gid, 0);
        step(1'b0);
        step(1'b0);
        check_eq("post_rst_gid3", s_gid, 3);
        step(1'b0);
        check_eq("arst_drain", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
